bpred_bimodal_update: RTL
=========================

Name: bpred_bimodal_update

Overview:
- Branch-direction and BTB-maintenance stage directly upstream of the predictor top.
- Holds a 512-entry table of 2-bit saturating counters; looks it up by fetch PC and drives the predictor top's `taken` input.
- Consumes resolved-branch results from execute and trains the counters.
- Queues BTB refills for taken indirect branches and drains them onto the predictor top's `wren`/`w_addr`/`w_data` write port.

Parameters:
- IDX_W, 9, counter-table index width (2^IDX_W entries)
- BTB_AW, 8, BTB write-address width
- WQ_DEPTH, 4, BTB write-queue depth (power of two)
- CTR_INIT, 2'b01, counter value after init sweep (weakly not-taken)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- lu_valid  in  1  lookup request this cycle
- lu_pc  in  32  fetch PC to predict
- taken  out  1  registered prediction, feeds predictor top
- taken_valid  out  1  `taken` corresponds to a lookup accepted last cycle
- up_valid  in  1  resolved branch presented
- up_ready  out  1  update accepted when up_valid & up_ready
- up_pc  in  32  PC of resolved branch
- up_taken  in  1  actual direction
- up_indirect  in  1  target not computable from instruction (register jump/call/ret)
- up_target  in  32  actual target
- wren  out  1  BTB write strobe
- w_addr  out  BTB_AW  BTB index
- w_data  out  32  BTB word
- init_busy  out  1  counter init sweep in progress

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - FSM to INIT, sweep index 0
  - taken=0, taken_valid=0, wren=0, w_addr=0, w_data=0
  - write queue empty, up_ready=0, init_busy=1
- FSM INIT:
  - Writes CTR_INIT to entry[sweep index] each cycle and increments the index.
  - After entry 2^IDX_W-1 is written (512 cycles), moves to RUN; init_busy falls the same edge.
  - Lookups in INIT: taken=0, taken_valid=0. up_ready=0.
- FSM RUN:
  - Stays in RUN until reset.
  - Reset mid-sweep restarts the sweep from 0.
- Index = pc[IDX_W+1:2] for both lookup and update.
- Lookup latency is 1 cycle: taken = ctr[lu index][1], registered; taken_valid = lu_valid registered (RUN only).
- Update (up_valid & up_ready in RUN) counter rule:
  - up_taken=1: ctr = min(ctr+1, 3)
  - up_taken=0: ctr = max(ctr-1, 0)
  - The counter saturates and never wraps.
- Same-index lookup and update in one cycle: the lookup returns the pre-update counter (read-before-write), unless the optional feature is enabled.
- BTB write queue (WQ_DEPTH FIFO):
  - Push on an accepted update with up_taken=1 & up_indirect=1.
  - Entry = {addr = up_pc[BTB_AW+1:2], data = {2'b00, up_target[31:2]}}.
  - Pop one entry per cycle when non-empty; popped entry is presented registered on w_addr/w_data with wren=1 for exactly one cycle.
  - wren=0 when empty.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- up_ready = (state==RUN) & !queue_full.
  - Full plus a simultaneous pop still deasserts up_ready: no combinational pop-to-ready path.
  - Counter training stalls with the queue, so no update is ever lost.
- Non-indirect or not-taken updates train the counter only and push nothing.
- Queue pointers wrap modulo WQ_DEPTH; a full/empty flag bit is carried separately.

Optional Feature:
- Macro BPRED_BYPASS_EN.
- Defined: when an accepted update and a lookup hit the same index in the same cycle, `taken` next cycle reflects the post-update counter's MSB.
- Undefined: read-before-write as above; the old counter's MSB is returned.

Test Plan:
- Reset, hold lu_valid=1, lu_pc=0:
  - init_busy=1 and up_ready=0 for 512 cycles, then both flip.
  - First post-init lookup gives taken_valid=1, taken=0.
- Three taken updates at up_pc=0x40, then lookup 0x40:
  - Counter 01→10→11→11 (saturated).
  - taken=1 after the first update.
  - Two not-taken updates then give taken=0.
- Taken indirect update, up_pc=0x104, up_target=0x2000:
  - Within 2 cycles: one-cycle pulse wren=1, w_addr=0x41, w_data=0x00000800.
- Five back-to-back taken indirect updates with the queue started empty (draining one per cycle):
  - No update is lost: exactly five wren pulses in order.
  - up_ready drops only when occupancy reaches 4.
- Same-cycle update (taken, entry at 01) and lookup at 0x80:
  - taken=0 without BPRED_BYPASS_EN.
  - taken=1 with it.
- Assert rst_n low mid-sweep at index 200 and mid-queue with 3 entries:
  - Outputs clear immediately.
  - Queue empties.
  - Sweep restarts at 0 and again takes 512 cycles.

Source files
------------

// File: rtl/bpred_bimodal_update.sv
// Bimodal 2-bit counter predictor with training and a BTB refill queue for taken indirect branches.
// Optional macro BPRED_BYPASS_EN: same-cycle update-to-lookup forwarding of the new counter.
module bpred_bimodal_update #(
    parameter int unsigned IDX_W    = 9,
    parameter int unsigned BTB_AW   = 8,
    parameter int unsigned WQ_DEPTH = 4,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lu_valid,
    input  logic [31:0]       lu_pc,
    output logic              taken,
    output logic              taken_valid,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [31:0]       up_pc,
    input  logic              up_taken,
    input  logic              up_indirect,
    input  logic [31:0]       up_target,
    output logic              wren,
    output logic [BTB_AW-1:0] w_addr,
    output logic [31:0]       w_data,
    output logic              init_busy
);

    localparam int unsigned Entries = 2 ** IDX_W;
    localparam int unsigned WqAw    = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
    localparam logic [IDX_W-1:0] IdxOne = 1;
    localparam logic [WqAw-1:0]  PtrOne = 1;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic run;

    logic [1:0] ctr_q [Entries];

    logic [IDX_W-1:0] lu_idx, up_idx;
    logic [1:0] up_ctr, up_ctr_nxt, lu_ctr;
    logic upd_fire;

    logic [BTB_AW-1:0] wq_addr_q [WQ_DEPTH];
    logic [31:0]       wq_data_q [WQ_DEPTH];
    logic [WqAw-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic              full_q, full_d;
    logic              empty, push, pop;

    logic taken_q, taken_valid_q, wren_q;
    logic [BTB_AW-1:0] w_addr_q;
    logic [31:0] w_data_q;

    logic unused_bits;
    assign unused_bits = ^{lu_pc, up_pc, up_target[1:0]};

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            StInit: begin
                sweep_d = sweep_q + IdxOne;
                if (sweep_q == {IDX_W{1'b1}}) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        init_busy = 1'b0;
        run       = 1'b0;
        unique case (state_q)
            StInit:  init_busy = 1'b1;
            StRun:   run       = 1'b1;
            default: init_busy = 1'b1;
        endcase
    end

    // ---------------- Counter table ----------------
    assign lu_idx   = lu_pc[IDX_W+1:2];
    assign up_idx   = up_pc[IDX_W+1:2];
    assign up_ready = run & ~full_q;
    assign upd_fire = up_valid & up_ready;
    assign up_ctr   = ctr_q[up_idx];

    always_comb begin
        up_ctr_nxt = up_ctr;
        if (up_taken) begin
            if (up_ctr != 2'b11) up_ctr_nxt = up_ctr + 2'b01;
        end else begin
            if (up_ctr != 2'b00) up_ctr_nxt = up_ctr - 2'b01;
        end
    end

    always_comb begin
        lu_ctr = ctr_q[lu_idx];
`ifdef BPRED_BYPASS_EN
        if (upd_fire && (up_idx == lu_idx)) begin
            lu_ctr = up_ctr_nxt;
        end
`endif
    end

    // Table is not reset; the init sweep gives every entry a defined value before RUN.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            ctr_q[sweep_q] <= CTR_INIT;
        end else if (upd_fire) begin
            ctr_q[up_idx] <= up_ctr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q       <= 1'b0;
            taken_valid_q <= 1'b0;
        end else begin
            taken_valid_q <= run & lu_valid;
            taken_q       <= (run & lu_valid) ? lu_ctr[1] : 1'b0;
        end
    end

    assign taken       = taken_q;
    assign taken_valid = taken_valid_q;

    // ---------------- BTB write queue ----------------
    assign empty = (wptr_q == rptr_q) & ~full_q;
    assign push  = upd_fire & up_taken & up_indirect;
    assign pop   = ~empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        full_d = full_q;
        if (push) wptr_d = wptr_q + PtrOne;
        if (pop)  rptr_d = rptr_q + PtrOne;
        if (push && !pop && (wptr_d == rptr_q)) begin
            full_d = 1'b1;
        end else if (pop && !push) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            full_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            full_q <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wq_addr_q[wptr_q] <= up_pc[BTB_AW+1:2];
            wq_data_q[wptr_q] <= {2'b00, up_target[31:2]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wren_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            wren_q <= pop;
            if (pop) begin
                w_addr_q <= wq_addr_q[rptr_q];
                w_data_q <= wq_data_q[rptr_q];
            end
        end
    end

    assign wren   = wren_q;
    assign w_addr = w_addr_q;
    assign w_data = w_data_q;

endmodule
